// File: rtl/gf64_pkg.sv
// Shared definitions for the GF(2^6) power-map engine.
//   GF_W    : field element width
//   GF_POLY : low-order terms of the reduction polynomial x^6 + x + 1
//   GF_ONE  : multiplicative identity
//   state_e : controller states of gf64_pow_iter
package gf64_pkg;

  localparam int unsigned      GF_W    = 6;
  localparam logic [GF_W-1:0]  GF_POLY = 6'b000011;
  localparam logic [GF_W-1:0]  GF_ONE  = 6'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gf64_mul.sv
// Combinational GF(2^6) multiplier, polynomial basis, modulo x^6 + x + 1.
//   a_i : first operand
//   b_i : second operand
//   p_o : a_i * b_i reduced into the field
module gf64_mul
  import gf64_pkg::*;
(
  input  logic [GF_W-1:0] a_i,
  input  logic [GF_W-1:0] b_i,
  output logic [GF_W-1:0] p_o
);

  localparam int unsigned PW = 2 * GF_W - 1;

  logic [PW-1:0] prod;
  logic [PW-1:0] red;

  // Full carry-less product.
  always_comb begin
    prod = '0;
    for (int i = 0; i < GF_W; i++) begin
      if (b_i[i]) begin
        prod = prod ^ ({{(GF_W-1){1'b0}}, a_i} << i);
      end
    end
  end

  // Fold the high terms down from the top: x^k = x^(k-6) * (x + 1).
  always_comb begin
    red = prod;
    for (int i = PW - 1; i >= GF_W; i--) begin
      if (red[i]) begin
        red[i]                 = 1'b0;
        red[i-GF_W +: GF_W]    = red[i-GF_W +: GF_W] ^ GF_POLY;
      end
    end
  end

  assign p_o = red[GF_W-1:0];

endmodule

// File: rtl/gf64_pow_iter.sv
// Serial GF(2^6) power-map engine: out = in^EXP, MSB-first square-and-multiply,
// one exponent bit per clock.
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   in_valid_i : operand valid
//   in_ready_o : engine idle and able to accept an operand
//   in_data_i  : operand x, polynomial basis
//   out_valid_o: result valid, held until accepted
//   out_ready_i: consumer accepts the result
//   out_data_o : x^EXP, polynomial basis
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | scanning exponent bits EXP_W-1 .. 0, one per cycle
// DONE  | result presented, waiting for out_ready
module gf64_pow_iter
  import gf64_pkg::*;
#(
  parameter int unsigned EXP   = 52,
  parameter int unsigned EXP_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [GF_W-1:0] in_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [GF_W-1:0] out_data_o
);

  if (EXP > 63) begin : g_exp_range
    $fatal(1, "gf64_pow_iter: EXP must be in 0..63");
  end

  localparam int unsigned       IDX_W    = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [EXP_W-1:0]  EXP_BITS = EXP_W'(EXP);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(EXP_W - 1);

  state_e           state_q, state_d;
  logic [GF_W-1:0]  acc_q, acc_d;
  logic [GF_W-1:0]  op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [GF_W-1:0]  sq_res;
  logic [GF_W-1:0]  mul_res;

  gf64_mul u_sq (
    .a_i (acc_q),
    .b_i (acc_q),
    .p_o (sq_res)
  );

  gf64_mul u_mul (
    .a_i (sq_res),
    .b_i (op_q),
    .p_o (mul_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      idx_q   <= IDX_TOP;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    idx_d       = idx_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          op_d    = in_data_i;
          acc_d   = GF_ONE;
          idx_d   = IDX_TOP;
          state_d = RUN;
        end
      end

      RUN: begin
        // Leading zero exponent bits square 1 and so keep acc at 1.
        acc_d = EXP_BITS[idx_q] ? mul_res : sq_res;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_data_o = acc_q;

endmodule

// File: tb/tb_gf64_pow_iter.sv
module tb_gf64_pow_iter;
  import gf64_pkg::*;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [5:0] in_data   [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];
  logic [5:0] out_data  [NI];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int outstanding = 0;

  typedef struct {
    int         inst;
    logic [5:0] val;
  } hand_t;

  hand_t hq[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // Reference model: shift-and-reduce multiply, exponent by repeated product.
  function automatic logic [5:0] gmul_m(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r;
    logic [5:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[4:0], 1'b0} ^ (t[5] ? 6'h03 : 6'h00);
    end
    return r;
  endfunction

  function automatic logic [5:0] pow_m(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < e; i++) r = gmul_m(r, x);
    return r;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g
    localparam int E = (k == 0) ? 52 : (k == 1) ? 0 : (k == 2) ? 1 : 63;

    gf64_pow_iter #(.EXP(E), .EXP_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid[k]),
      .in_ready_o  (in_ready[k]),
      .in_data_i   (in_data[k]),
      .out_valid_o (out_valid[k]),
      .out_ready_i (out_ready[k]),
      .out_data_o  (out_data[k])
    );

    logic [5:0] mq[$];
    int         acc_cyc = 0;
    bit         pend = 1'b0;

    always @(negedge clk) begin
      logic [5:0] e;
      hand_t      h;
      if (rst) begin
        outstanding = outstanding - mq.size();
        mq.delete();
        pend = 1'b0;
        if (out_valid[k]) chk($sformatf("valid_during_rst[%0d]", k), 1, 0);
      end else begin
        if (out_valid[k] && pend) begin
          chk($sformatf("latency[%0d]", k), cyc - acc_cyc, 7);
          pend = 1'b0;
        end
        if (out_valid[k] && out_ready[k]) begin
          if (mq.size() == 0) begin
            chk($sformatf("unexpected_out[%0d]", k), 1, 0);
          end else begin
            e = mq.pop_front();
            outstanding--;
            chk($sformatf("model[%0d]", k), int'(out_data[k]), int'(e));
            if (hq.size() > 0 && hq[0].inst == k) begin
              h = hq.pop_front();
              chk($sformatf("hand[%0d]", k), int'(out_data[k]), int'(h.val));
            end
          end
        end
        if (in_valid[k] && in_ready[k]) begin
          mq.push_back(pow_m(in_data[k], E));
          outstanding++;
          acc_cyc = cyc;
          pend = 1'b1;
        end
      end
    end
  end

  // Drive an operand until accepted; returns the cycle of the accepting edge.
  task automatic send(input int k, input logic [5:0] d, input bit drop,
                      input bit hand_en, input logic [5:0] hand, output int acc_at);
    bit ok;
    hand_t h;
    ok = 1'b0;
    acc_at = -1;
    if (hand_en) begin
      h.inst = k;
      h.val  = hand;
      hq.push_back(h);
    end
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready[k] && !rst) begin
        ok = 1'b1;
        acc_at = cyc;
        break;
      end
    end
    if (!ok) chk($sformatf("accept_timeout[%0d]", k), 0, 1);
    @(posedge clk);
    #1;
    if (drop) begin
      in_valid[k] = 1'b0;
      in_data[k]  = ~d;
    end
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("idle_timeout[%0d]", k), 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  t0;
    int  t1;
    bit  ok;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_in_ready[%0d]", k), int'(in_ready[k]), 1);
      chk($sformatf("rst_out_valid[%0d]", k), int'(out_valid[k]), 0);
      chk($sformatf("rst_out_data[%0d]", k), int'(out_data[k]), 0);
    end
    @(posedge clk);
    #1;

    // Reset and in_valid together: nothing is accepted.
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 6'h02;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_wins_in_ready", int'(in_ready[0]), 1);
    @(posedge clk);
    #1;

    // Single transfers, EXP=52.
    send(0, 6'h02, 1'b1, 1'b1, 6'h15, t0); wait_idle(0);
    send(0, 6'h03, 1'b1, 1'b1, 6'h39, t0); wait_idle(0);
    send(0, 6'h01, 1'b1, 1'b1, 6'h01, t0); wait_idle(0);
    send(0, 6'h00, 1'b1, 1'b1, 6'h00, t0); wait_idle(0);

    // Backpressure.
    out_ready[0] = 1'b0;
    send(0, 6'h02, 1'b1, 1'b1, 6'h15, t0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("bp_valid_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid[0]), 1);
      chk("bp_out_data", int'(out_data[0]), 'h15);
      chk("bp_in_ready", int'(in_ready[0]), 0);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_xfer_valid", int'(out_valid[0]), 1);
    @(negedge clk);
    chk("bp_after_in_ready", int'(in_ready[0]), 1);
    chk("bp_after_out_valid", int'(out_valid[0]), 0);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held high.
    send(0, 6'h02, 1'b0, 1'b1, 6'h15, t0);
    in_data[0] = 6'h03;
    send(0, 6'h03, 1'b1, 1'b1, 6'h39, t1);
    chk("b2b_spacing", t1 - t0, 8);
    wait_idle(0);

    // Reset mid-RUN.
    send(0, 6'h02, 1'b1, 1'b0, 6'h00, t0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_in_ready", int'(in_ready[0]), 1);
    chk("midrun_out_valid", int'(out_valid[0]), 0);
    chk("midrun_out_data", int'(out_data[0]), 0);
    @(posedge clk);
    #1;
    send(0, 6'h03, 1'b1, 1'b1, 6'h39, t0); wait_idle(0);

    // Other exponents, directed.
    send(1, 6'h00, 1'b1, 1'b1, 6'h01, t0); wait_idle(1);
    send(2, 6'h2A, 1'b1, 1'b1, 6'h2A, t0); wait_idle(2);
    send(3, 6'h15, 1'b1, 1'b1, 6'h01, t0); wait_idle(3);

    // Random operands against the reference model.
    for (int k = 1; k < NI; k++) begin
      for (int i = 0; i < 1000; i++) begin
        send(k, 6'($urandom_range(0, 63)), 1'b1, 1'b0, 6'h00, t0);
      end
      wait_idle(k);
    end
    for (int i = 0; i < 200; i++) begin
      send(0, 6'($urandom_range(0, 63)), 1'b1, 1'b0, 6'h00, t0);
    end
    wait_idle(0);

    repeat (3) @(negedge clk);
    chk("drain_outstanding", outstanding, 0);
    chk("drain_hand", hq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gf64_pow_iter.md
Name: gf64_pow_iter

Overview:
- Multi-cycle GF(2^6) power-map engine: accepts one 6-bit field element per handshake and returns x^EXP using MSB-first square-and-multiply, one exponent bit per cycle.
- Field arithmetic is in polynomial basis, reduction polynomial x^6+x+1.
- Sits directly upstream of the combinational power-map S-box.
- Serves as the small-area serial alternative to that S-box and as its in-system golden checker; with default EXP=52, results must match the S-box bit-for-bit on the polynomial-basis side.

Parameters:
- EXP, 52, exponent applied to every input, 0..63.
- EXP_W, 6, number of exponent bits scanned; one iteration per bit.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid operand.
- in_ready  output  1  engine can accept an operand.
- in_data  input  6  operand x, polynomial basis, bit i is the coefficient of a^i.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  6  x^EXP, polynomial basis.

Behaviour:
- Clock and reset (already decided): one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, internal acc=0, operand reg=0, bit index=EXP_W-1.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: operand reg<=in_data, acc<=6'h01, idx<=EXP_W-1, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle: acc <= EXP[idx] ? mul(sq(acc), op) : sq(acc); idx decrements. When idx==0 is processed, go to DONE.
  - DONE: out_valid=1, out_data=acc, held stable until out_ready. On out_valid&out_ready, go to IDLE.
- Latency: operand accepted at edge ending cycle T; RUN occupies cycles T+1..T+EXP_W; out_valid=1 from cycle T+EXP_W+1 (T+7 with defaults).
- Throughput: one result per EXP_W+2 cycles with out_ready tied high. No new input is accepted while in DONE, even if out_ready=1 in the same cycle.
- Backpressure: out_ready low holds DONE indefinitely. out_data must not change, and in_ready stays 0.
- Arithmetic:
  - sq and mul reduce modulo x^6+x+1; every product is a full 11-bit carry-less product, reduced combinationally within the cycle.
  - Leading zero bits of EXP leave acc=1.
- Boundary cases:
  - x=0 with EXP>0 gives 0.
  - EXP=0 gives 1 for all x, including 0^0=1.
  - EXP=63 gives 1 for every nonzero x.
  - EXP>63 is illegal; elaboration fails.
- in_data is sampled only on the accepting edge; later changes have no effect.
- rst asserted in any state, including mid-RUN or DONE with out_ready low: the next edge returns all registers to reset values. The in-flight operand is discarded and no out_valid pulse is emitted.
- rst and in_valid high in the same cycle: reset wins, nothing is accepted.

Decomposition:
- Package gf64_pkg holds:
  - GF_W=6;
  - GF_POLY=6'b000011 (low terms of x^6+x+1);
  - GF_ONE=6'h01;
  - the state enum {IDLE, RUN, DONE}.
- Sub-module gf64_mul: purely combinational 6x6 polynomial-basis multiply with reduction. It is instantiated twice: once as sq (acc,acc) and once as mul (sq result, operand).
- FSM, counter and handshake logic stay in gf64_pow_iter.

Test Plan:
- Reset then single transfers, out_ready=1, EXP=52:
  - in 0x02 -> out 0x15 with out_valid first high exactly 7 cycles after the accept edge;
  - in 0x03 -> out 0x39;
  - in 0x01 -> out 0x01;
  - in 0x00 -> out 0x00.
- Backpressure: in 0x02, hold out_ready=0 for 10 cycles -> out_valid stays 1, out_data stays 0x15, in_ready stays 0. Raise out_ready -> one transfer, then in_ready=1 the next cycle.
- Back-to-back: in_valid held high with 0x02 then 0x03 -> accepts spaced 8 cycles apart, outputs 0x15 then 0x39, no duplicated or dropped results.
- Reset mid-RUN: accept 0x02, assert rst in cycle T+3 -> next cycle in_ready=1, out_valid=0, out_data=0. A subsequent 0x03 yields 0x39.
- Parameter sweep, EXP in {0,1,63}: EXP=0, in 0x00 -> 0x01. EXP=1, in 0x2A -> 0x2A. EXP=63, in 0x15 -> 0x01. Random 1000 operands per EXP checked against a software model.
